// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: word-op sign extension, x0 write suppression, MEM forwarding source.
// Latency 1 cycle; outputs come only from registers. Define EX_MEM_SKID_EN for a registered-ready
// head+skid pair; otherwise a single head register whose ex_ready follows mem_ready combinationally.
module ex_mem_reg #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_res,
    input  logic              ex_word,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic              ex_rd_wen,
    input  logic [CTRL_W-1:0] ex_mem_ctrl,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_res,
    output logic [RD_W-1:0]   mem_rd,
    output logic              mem_rd_wen,
    output logic [CTRL_W-1:0] mem_mem_ctrl,
    output logic [DATA_W-1:0] mem_store_data,
    output logic              fwd_wen,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [RD_W-1:0]   rd;
        logic              wen;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] sd;
    } ent_t;

    ent_t in_ent;
    ent_t h_ent;
    logic h_valid;
    logic accept;
    logic pop;

    // The EX shifter leaves *W results unextended; finish the job here.
    always_comb begin
        in_ent      = '0;
        in_ent.res  = ex_word ? {{(DATA_W-32){ex_res[31]}}, ex_res[31:0]} : ex_res;
        in_ent.rd   = ex_rd;
        in_ent.wen  = ex_rd_wen & (ex_rd != '0);
        in_ent.ctrl = ex_mem_ctrl;
        in_ent.sd   = ex_store_data;
    end

    assign accept = ex_valid & ex_ready;
    assign pop    = h_valid & mem_ready;

`ifdef EX_MEM_SKID_EN
    ent_t s_ent;
    logic s_valid;

    assign ex_ready = ~s_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_valid <= 1'b0;
            h_ent   <= '0;
            s_valid <= 1'b0;
            s_ent   <= '0;
        end else if (flush) begin
            h_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (!h_valid) begin
            if (accept) begin
                h_ent   <= in_ent;
                h_valid <= 1'b1;
            end
        end else if (pop) begin
            if (s_valid) begin
                h_ent   <= s_ent;
                s_valid <= 1'b0;
            end else if (accept) begin
                h_ent   <= in_ent;
            end else begin
                h_valid <= 1'b0;
            end
        end else if (accept) begin
            s_ent   <= in_ent;
            s_valid <= 1'b1;
        end
    end
`else
    assign ex_ready = ~h_valid | mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_valid <= 1'b0;
            h_ent   <= '0;
        end else if (flush) begin
            h_valid <= 1'b0;
        end else if (accept) begin
            h_ent   <= in_ent;
            h_valid <= 1'b1;
        end else if (pop) begin
            h_valid <= 1'b0;
        end
    end
`endif

    // Saturating; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (h_valid && !mem_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign mem_valid      = h_valid;
    assign mem_res        = h_ent.res;
    assign mem_rd         = h_ent.rd;
    assign mem_rd_wen     = h_ent.wen;
    assign mem_mem_ctrl   = h_ent.ctrl;
    assign mem_store_data = h_ent.sd;
    assign fwd_wen        = h_valid & h_ent.wen;
    assign fwd_rd         = h_ent.rd;
    assign fwd_data       = h_ent.res;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized and directed bench for ex_mem_reg against a queue-based reference model.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_res;
    logic        ex_word;
    logic [4:0]  ex_rd;
    logic        ex_rd_wen;
    logic [7:0]  ex_mem_ctrl;
    logic [63:0] ex_store_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_res;
    logic [4:0]  mem_rd;
    logic        mem_rd_wen;
    logic [7:0]  mem_mem_ctrl;
    logic [63:0] mem_store_data;
    logic        fwd_wen;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic [31:0] stall_cnt;

    ex_mem_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_res(ex_res), .ex_word(ex_word),
        .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen), .ex_mem_ctrl(ex_mem_ctrl),
        .ex_store_data(ex_store_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_res(mem_res), .mem_rd(mem_rd),
        .mem_rd_wen(mem_rd_wen), .mem_mem_ctrl(mem_mem_ctrl), .mem_store_data(mem_store_data),
        .fwd_wen(fwd_wen), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        wen;
        logic [7:0]  ctrl;
        logic [63:0] sd;
    } ent_t;

    ent_t        q[$];
    longint unsigned cnt;
    int          n_chk  = 0;
    int          n_pass = 0;
    bit          last_acc;

`ifdef EX_MEM_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic bit model_ready();
        if (CAP == 2) return q.size() < 2;
        return q.size() == 0 || mem_ready;
    endfunction

    function automatic ent_t xform();
        ent_t e;
        e.res  = ex_word ? 64'(longint'(int'(ex_res[31:0]))) : ex_res;
        e.rd   = ex_rd;
        e.wen  = ex_rd_wen && ex_rd != 0;
        e.ctrl = ex_mem_ctrl;
        e.sd   = ex_store_data;
        return e;
    endfunction

    task automatic drive(input bit v, input logic [63:0] r, input bit w, input logic [4:0] rd,
                         input bit wen);
        ex_valid      = v;
        ex_res        = r;
        ex_word       = w;
        ex_rd         = rd;
        ex_rd_wen     = wen;
        ex_mem_ctrl   = 8'($urandom);
        ex_store_data = {$urandom, $urandom};
    endtask

    // Check outputs mid-cycle, then advance the model across the next rising edge.
    task automatic cycle();
        bit acc, pp, stl;
        ent_t e;
        @(negedge clk);
        chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
        chk("ex_ready", 64'(ex_ready), 64'(model_ready()));
        chk("stall_cnt", 64'(stall_cnt), cnt);
        chk("fwd_wen", 64'(fwd_wen), 64'(q.size() != 0 && q[0].wen));
        if (q.size() != 0) begin
            chk("mem_res", mem_res, q[0].res);
            chk("mem_rd", 64'(mem_rd), 64'(q[0].rd));
            chk("mem_rd_wen", 64'(mem_rd_wen), 64'(q[0].wen));
            chk("mem_ctrl", 64'(mem_mem_ctrl), 64'(q[0].ctrl));
            chk("mem_sd", mem_store_data, q[0].sd);
            chk("fwd_rd", 64'(fwd_rd), 64'(q[0].rd));
            chk("fwd_data", fwd_data, q[0].res);
        end
        acc = ex_valid && model_ready();
        pp  = q.size() != 0 && mem_ready;
        stl = q.size() != 0 && !mem_ready;
        e   = xform();
        @(posedge clk);
        last_acc = acc && !flush;
        if (flush) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        if (stl && cnt != 64'hFFFF_FFFF) cnt++;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b1; cnt = 0;
        drive(0, 0, 0, 0, 0);
        #12;
        chk("rst_mem_valid", 64'(mem_valid), 0);
        chk("rst_stall_cnt", 64'(stall_cnt), 0);
        chk("rst_mem_res", mem_res, 0);
        chk("rst_mem_rd", 64'(mem_rd), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word op with sign extension.
        drive(1, 64'h0000_0000_8000_0001, 1, 5, 1);
        cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("single_res", mem_res, 64'hFFFF_FFFF_8000_0001);
        chk("single_fwd_wen", 64'(fwd_wen), 1);
        chk("single_fwd_rd", 64'(fwd_rd), 5);
        chk("single_ex_ready", 64'(ex_ready), 1);
        @(posedge clk); #1;
        void'(q.pop_front());

        // x0 destination never forwarded.
        drive(1, 64'h1234, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();

        // Back-pressure: A, B, then C held upstream until accepted.
        mem_ready = 1'b0;
        drive(1, 64'h1, 0, 1, 1); cycle();
        drive(1, 64'h2, 0, 2, 1); cycle();
        while (last_acc == 0 && n_chk < 100000) cycle();
        drive(1, 64'h3, 0, 3, 1);
        for (int i = 0; i < 3; i++) cycle();
        chk("bp_head_A", mem_res, 64'h1);
        mem_ready = 1'b1;
        begin
            int k = 0;
            while (k < 10) begin
                cycle();
                k++;
                if (last_acc && ex_res == 64'h3) break;
            end
            chk("bp_C_accepted", 64'(k < 10), 1);
        end
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();

        // Streaming 0..7 with no bubbles.
        for (int i = 0; i < 8; i++) begin
            drive(1, 64'(i), 0, 5'(i + 1), 1);
            cycle();
        end
        drive(0, 0, 0, 0, 0);
        cycle();

        // Flush with stage full and an input presented in the flush cycle.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 64'(16 + i), 0, 7, 1);
            cycle();
        end
        drive(1, 64'h9, 0, 9, 1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("flush_mem_valid", 64'(mem_valid), 0);
        chk("flush_ex_ready", 64'(ex_ready), 1);
        mem_ready = 1'b1;
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            mem_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 15) == 0;
            cycle();
        end
        flush = 1'b0;

        // Async reset in the middle of a stall.
        mem_ready = 1'b0;
        drive(1, 64'h55, 0, 3, 1); cycle();
        drive(0, 0, 0, 0, 0); cycle(); cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_valid", 64'(mem_valid), 0);
        chk("arst_stall_cnt", 64'(stall_cnt), 0);
        q.delete(); cnt = 0;
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        drive(1, 64'h0000_0000_7FFF_FFFF, 1, 4, 1);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();
        chk("post_arst_empty", 64'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
